// File: rtl/store_trace_fifo_pkg.sv
// Shared types for the store trace buffer: one captured store = address, data, cycle stamp.
package store_trace_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TS_W   = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   stamp;
  } trace_entry_t;

endpackage

// File: rtl/store_trace_fifo_if.sv
// Store-capture and trace-drain signals. The master side is the processor port plus the trace consumer.
interface store_trace_fifo_if #(
  parameter int TS_W = 16
) ();
  import store_trace_pkg::*;

  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              trc_valid;
  logic              trc_ready;
  logic [ADDR_W-1:0] trc_addr;
  logic [DATA_W-1:0] trc_data;
  logic [TS_W-1:0]   trc_stamp;

  modport master (
    output memwrite, dataadr, writedata, trc_ready,
    input  trc_valid, trc_addr, trc_data, trc_stamp
  );

  modport slave (
    input  memwrite, dataadr, writedata, trc_ready,
    output trc_valid, trc_addr, trc_data, trc_stamp
  );

endinterface

// File: rtl/store_trace_fifo_sync.sv
// Single-clock FIFO of trace entries; full/empty derive from an explicit occupancy count.
module trace_sync_fifo
  import store_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  trace_entry_t             din,
  output trace_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  // NOTE: storage is reset too, so the stale head driven onto the trace outputs reads zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_trace_fifo.sv
// Captures processor stores with a cycle stamp into a drainable trace FIFO with loss reporting.
// Optional address window filter: define STORE_TRACE_ADDR_FILTER_EN.
module store_trace_fifo #(
  parameter int          DEPTH   = 8,
  parameter int          TS_W    = 16,
  parameter int          DROP_W  = 8,
  parameter logic [31:0] LO_ADDR = 32'h0000_0000,
  parameter logic [31:0] HI_ADDR = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  store_trace_fifo_if.slave      bus,
  input  logic                   clr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);
  import store_trace_pkg::*;

`ifdef STORE_TRACE_ADDR_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic [TS_W-1:0] stamp_q;
  logic            in_window;
  logic            push_req;
  logic            drop;
  logic            full;
  logic            empty;
  trace_entry_t    entry_in;
  trace_entry_t    head;

  // Zero-extended compare keeps the inclusive all-ones bound from reading as a constant.
  assign in_window = !FILTER_ON ||
                     (({1'b0, bus.dataadr} >= {1'b0, LO_ADDR}) &&
                      ({1'b0, bus.dataadr} <= {1'b0, HI_ADDR}));
  assign push_req  = bus.memwrite && in_window;
  assign drop      = push_req && full && !bus.trc_ready && !clr;
  assign entry_in  = '{addr: bus.dataadr, data: bus.writedata, stamp: stamp_q};

  trace_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (push_req),
    .pop   (bus.trc_ready),
    .din   (entry_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.trc_valid = !empty;
  assign bus.trc_addr  = head.addr;
  assign bus.trc_data  = head.data;
  assign bus.trc_stamp = head.stamp;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stamp_q <= '0;
    else        stamp_q <= stamp_q + TS_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed bench for store_trace_fifo: capture, overflow, full push/pop, clr, async reset, filter window.
module tb_store_trace_fifo;

  logic       clk;
  logic       reset;
  logic       clr;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;
  int         passes;
  int         total;

  store_trace_fifo_if bus ();

  store_trace_fifo #(
    .DEPTH   (8),
    .TS_W    (16),
    .DROP_W  (8),
    .LO_ADDR (32'h0000_0058),
    .HI_ADDR (32'h0000_005C)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .clr      (clr),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.memwrite  = 1'b1;
    bus.dataadr   = addr;
    bus.writedata = data;
  endtask

  initial begin
    passes = 0;
    total  = 0;
    reset = 1'b0;
    clr   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.trc_ready = 1'b0;

    // Reset state
    #2;
    check("rst_valid", bus.trc_valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_addr", bus.trc_addr, 0);

    // Single store on the 4th edge after release carries stamp 3
    @(negedge clk);
    reset = 1'b1;
    step(); step(); step();
    store(32'h50, 32'h7);
    bus.trc_ready = 1'b1;
    step();
    bus.memwrite = 1'b0;
    check("cap_valid", bus.trc_valid, 1);
    check("cap_count", count, 1);
    check("cap_addr", bus.trc_addr, 32'h50);
    check("cap_data", bus.trc_data, 32'h7);
    check("cap_stamp", bus.trc_stamp, 3);
    step();
    check("pop_count", count, 0);
    check("pop_valid", bus.trc_valid, 0);
    step();
    check("empty_pop_count", count, 0);

    // Fill past capacity with the consumer stalled
    bus.trc_ready = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      store(32'h50 + 32'(4 * (i - 1)), 32'(i));
      step();
    end
    bus.memwrite = 1'b0;
    check("fill_count", count, 8);
    check("fill_overflow", overflow, 1);
    check("fill_drop", drop_cnt, 3);
    check("fill_head_data", bus.trc_data, 1);
    check("fill_head_addr", bus.trc_addr, 32'h50);
    // Hold stability while stalled
    step();
    check("stall_head_data", bus.trc_data, 1);

    // Full with simultaneous push and pop
    store(32'h58, 32'h32);
    bus.trc_ready = 1'b1;
    step();
    bus.memwrite = 1'b0;
    check("fullpp_count", count, 8);
    check("fullpp_drop", drop_cnt, 3);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_data_%0d", i), bus.trc_data, (i < 7) ? 32'(i + 2) : 32'h32);
      check($sformatf("drain_addr_%0d", i), bus.trc_addr, (i < 7) ? 32'h54 + 32'(4 * i) : 32'h58);
      step();
    end
    check("drain_count", count, 0);
    check("drain_valid", bus.trc_valid, 0);

    // Flush, then build 5 entries with 2 drops
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr0_overflow", overflow, 0);
    check("clr0_drop", drop_cnt, 0);
    bus.trc_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      store(32'h100 + 32'(4 * i), 32'(i));
      step();
    end
    bus.memwrite  = 1'b0;
    bus.trc_ready = 1'b1;
    step(); step(); step();
    check("pre_clr_count", count, 5);
    check("pre_clr_overflow", overflow, 1);
    check("pre_clr_drop", drop_cnt, 2);
    check("pre_clr_head", bus.trc_data, 4);

    // clr with concurrent store and pop: both discarded
    clr = 1'b1;
    store(32'h5C, 32'h17);
    step();
    clr = 1'b0;
    bus.memwrite = 1'b0;
    check("clr_count", count, 0);
    check("clr_valid", bus.trc_valid, 0);
    check("clr_overflow", overflow, 0);
    check("clr_drop", drop_cnt, 0);
    step();
    check("clr_store_gone", count, 0);

    // Drop counter saturates at all-ones
    bus.trc_ready = 1'b0;
    bus.memwrite  = 1'b1;
    for (int i = 0; i < 308; i++) step();
    bus.memwrite = 1'b0;
    check("sat_drop", drop_cnt, 8'hFF);
    check("sat_count", count, 8);

    // Async reset between edges mid-drain
    bus.trc_ready = 1'b1;
    step();
    check("mid_count", count, 7);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", bus.trc_valid, 0);
    check("arst_count", count, 0);
    check("arst_overflow", overflow, 0);
    check("arst_drop", drop_cnt, 0);

    // Stamp restarts at 0 on the first edge after release
    bus.trc_ready = 1'b0;
    store(32'h60, 32'hAA);
    @(negedge clk);
    reset = 1'b1;
    step();
    bus.memwrite = 1'b0;
    check("rel_valid", bus.trc_valid, 1);
    check("rel_stamp", bus.trc_stamp, 0);
    check("rel_addr", bus.trc_addr, 32'h60);

    // Address window: only active when the filter is compiled in
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h54 + 32'(4 * i), 32'(i + 1));
      step();
    end
    bus.memwrite = 1'b0;
`ifdef STORE_TRACE_ADDR_FILTER_EN
    check("filt_count", count, 2);
    check("filt_head", bus.trc_addr, 32'h58);
`else
    check("filt_count", count, 4);
    check("filt_head", bus.trc_addr, 32'h54);
`endif
    check("filt_drop", drop_cnt, 0);
    bus.trc_ready = 1'b1;
    step();
    bus.trc_ready = 1'b0;
`ifdef STORE_TRACE_ADDR_FILTER_EN
    check("filt_next", bus.trc_addr, 32'h5C);
`else
    check("filt_next", bus.trc_addr, 32'h58);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/store_trace_fifo.md
Name: store_trace_fifo

Overview:
- Sits directly downstream of the MIPS `top` data-memory write port (`memwrite`/`dataadr`/`writedata`).
- Captures every store into a buffered trace (address, data, cycle stamp).
- A consumer (bench monitor, debug UART, perf logic) drains the trace over a valid/ready interface.
- Decouples store bursts from a slow reader; loss is reported explicitly.

Parameters:
- DEPTH, 8: trace entries; power of two, >= 2.
- TS_W, 16: cycle-stamp width.
- DROP_W, 8: dropped-store counter width.
- LO_ADDR, 32'h0000_0000: filter window low bound, inclusive; used only with the filter macro.
- HI_ADDR, 32'hFFFF_FFFF: filter window high bound, inclusive; used only with the filter macro.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  store strobe from processor; one store per cycle high.
- dataadr  in  32  store byte address.
- writedata  in  32  store data.
- clr  in  1  synchronous flush of FIFO, overflow, drop_cnt.
- trc_valid  out  1  head entry available.
- trc_ready  in  1  consumer accepts head.
- trc_addr  out  32  head address.
- trc_data  out  32  head data.
- trc_stamp  out  TS_W  head cycle stamp.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky, store lost.
- drop_cnt  out  DROP_W  stores lost, saturating.

Behaviour:
- Reset (reset=0, async): all outputs 0, pointers 0, stamp counter 0; takes effect without a clock edge. Release is synchronous to clk.
- Stamp counter: increments every cycle out of reset and wraps modulo 2^TS_W. A store captures the pre-increment value, so a store sampled on the first edge after release has stamp 0. clr does not affect the stamp counter.
- Push: on an edge with memwrite=1 (and accepted by the filter, if compiled), {dataadr, writedata, stamp} is written at the tail.
- Pop: on an edge with trc_valid && trc_ready, head advances. trc_* outputs are stable while trc_valid=1 and trc_ready=0.
- Latency: no bypass. A store into an empty FIFO raises trc_valid on the following cycle.
- trc_valid equals (count != 0). count updates the cycle after the push/pop edge.
- Full, push, no pop: store dropped, entries unchanged, overflow<=1, drop_cnt<=drop_cnt+1, saturating at all-ones.
- Full, push, pop same edge: both occur, count stays DEPTH, no drop.
- Empty, pop request: ignored (trc_valid=0).
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are distinguished by count.
- clr=1: pointers, count, overflow, drop_cnt <= 0. Any store and pop on the same edge are discarded and not counted as drops.
- trc_* data outputs with trc_valid=0 are don't-care for the checker; RTL drives the stale head.

Optional Feature:
- Macro: STORE_TRACE_ADDR_FILTER_EN.
- Defined: a store is captured only if LO_ADDR <= dataadr <= HI_ADDR (unsigned). Filtered-out stores are neither pushed nor counted as drops.
- Undefined: every store is captured; LO_ADDR/HI_ADDR are ignored.

Decomposition:
- Package `store_trace_pkg`:
  - Typedef `trace_entry_t` (packed struct: addr[31:0], data[31:0], stamp[TS_W-1:0], with TS_W default as package constant).
  - Localparam ADDR_W=32, DATA_W=32.
- Sub-module `trace_sync_fifo`:
  - Generic single-clock FIFO with push/pop/full/empty/count over `trace_entry_t`, async active-low reset, synchronous clr.
  - Top level adds stamp counter, filter, overflow/drop logic and the valid/ready mapping.

Test Plan:
- Store capture: release reset; store 0x7 to 0x50 on the 4th edge (stamp 3), trc_ready=1 -> next cycle trc_valid=1, trc_addr=0x50, trc_data=0x7, trc_stamp=3. After the pop, count=0 and trc_valid=0.
- Fill and overflow: DEPTH=8, trc_ready=0. Stores to 0x50,0x54,0x58,... with data 1..11 -> count=8, overflow=1, drop_cnt=3. Draining yields data 1..8 in order with 0x50..0x6C.
- Full with simultaneous push/pop: FIFO full, push data 0x32@0x58 with trc_ready=1 -> count stays 8, drop_cnt unchanged, 0x32 emerges 8th after the current head.
- clr: 5 entries, overflow=1, drop_cnt=2; assert clr with concurrent store 0x17@0x5C -> next cycle count=0, trc_valid=0, overflow=0, drop_cnt=0. That store never appears.
- Async reset mid-drain: pull reset low between clock edges -> trc_valid, count, overflow, drop_cnt read 0 before the next edge. After release, the stamp restarts at 0.
- Filter (macro defined, LO=0x58, HI=0x5C): stores to 0x54,0x58,0x5C,0x60 -> only 0x58 and 0x5C captured, drop_cnt=0. With the macro undefined, all four are captured.
